// File: rtl/fence_flush_sequencer.sv
// Orders cache/TLB maintenance behind FENCE, FENCE.I and SFENCE.VMA:
// drain store buffer, D$ flush handshake, I$ flush + settle, TLB flush, done.
module fence_flush_sequencer #(
   parameter bit          WT_DCACHE        = 1'b0,
   parameter int unsigned IC_SETTLE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic fence_i,
   input  logic fence_i_i,
   input  logic sfence_vma_i,
   input  logic store_buffer_empty_i,
   output logic flush_dcache_o,
   input  logic flush_dcache_ack_i,
   output logic flush_icache_o,
   output logic flush_tlb_o,
   output logic busy_o,
   output logic done_o
);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      DC_FLUSH,
      IC_FLUSH,
      TLB,
      DONE
   } state_e;

   localparam logic [7:0] SETTLE_INIT = 8'(IC_SETTLE_CYCLES);

   // Mask bit order: [2] sfence, [1] fence.i, [0] fence
   logic [2:0] req;
   state_e     state_reg, state_next;
   logic [2:0] cur_mask_reg, cur_mask_next;
   logic [2:0] next_mask_reg, next_mask_next;
   logic [7:0] settle_reg, settle_next;
   logic       flush_dcache_reg, flush_icache_reg, flush_tlb_reg;
   logic       busy_reg, done_reg;

   assign req = {sfence_vma_i, fence_i_i, fence_i};

   function automatic state_e after_dcache(input logic [2:0] m);
      if (m[1]) begin
         return IC_FLUSH;
      end else if (m[2]) begin
         return TLB;
      end
      return DONE;
   endfunction

   function automatic state_e after_drain(input logic [2:0] m);
      if ((m[0] | m[1]) && !WT_DCACHE) begin
         return DC_FLUSH;
      end
      return after_dcache(m);
   endfunction

   always_comb begin
      state_next     = state_reg;
      cur_mask_next  = cur_mask_reg;
      next_mask_next = next_mask_reg;
      settle_next    = settle_reg;

      // Requests seen while busy accumulate into one follow-up pass
      if (state_reg != IDLE) begin
         next_mask_next = next_mask_reg | req;
      end

      case (state_reg)
         IDLE: begin
            if (req != 3'b000) begin
               cur_mask_next = req;
               state_next    = DRAIN;
            end
         end
         DRAIN: begin
            if (store_buffer_empty_i) begin
               state_next = after_drain(cur_mask_reg);
            end
         end
         DC_FLUSH: begin
            if (flush_dcache_ack_i) begin
               state_next = after_dcache(cur_mask_reg);
            end
         end
         IC_FLUSH: begin
            if (settle_reg == 8'd0) begin
               state_next = cur_mask_reg[2] ? TLB : DONE;
            end else begin
               settle_next = settle_reg - 8'd1;
            end
         end
         TLB: begin
            state_next = DONE;
         end
         DONE: begin
            if ((next_mask_reg | req) != 3'b000) begin
               cur_mask_next  = next_mask_reg | req;
               next_mask_next = 3'b000;
               state_next     = DRAIN;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if ((state_next == IC_FLUSH) && (state_reg != IC_FLUSH)) begin
         settle_next = SETTLE_INIT;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         cur_mask_reg  <= 3'b000;
         next_mask_reg <= 3'b000;
         settle_reg    <= 8'd0;
      end else begin
         state_reg     <= state_next;
         cur_mask_reg  <= cur_mask_next;
         next_mask_reg <= next_mask_next;
         settle_reg    <= settle_next;
      end
   end

   // The counter still holds its load value only on the first IC_FLUSH cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flush_dcache_reg <= 1'b0;
         flush_icache_reg <= 1'b0;
         flush_tlb_reg    <= 1'b0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
      end else begin
         flush_dcache_reg <= (state_reg == DC_FLUSH);
         flush_icache_reg <= (state_reg == IC_FLUSH) && (settle_reg == SETTLE_INIT);
         flush_tlb_reg    <= (state_reg == TLB);
         busy_reg         <= (state_next != IDLE);
         done_reg         <= (state_reg == DONE);
      end
   end

   assign flush_dcache_o = flush_dcache_reg;
   assign flush_icache_o = flush_icache_reg;
   assign flush_tlb_o    = flush_tlb_reg;
   assign busy_o         = busy_reg;
   assign done_o         = done_reg;

endmodule

// File: tb/tb_fence_flush_sequencer.sv
// Bench for fence_flush_sequencer: per-pass event lists queued at issue time,
// popped and compared by an independent monitor as the DUT produces events.
module tb_fence_flush_sequencer;

   localparam int N    = 4;
   localparam int LOOP = 14;
   localparam int K_DC = 0, K_IC = 1, K_TLB = 2, K_DONE = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic fence, fencei, sfence, sb_empty;
   logic dc_ack, ack_auto, ack_dir, auto_ack;
   logic dc_o, ic_o, tlb_o, busy, done;
   logic w_fence;
   logic w_dc, w_ic, w_tlb, w_busy, w_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int txn_no = 0;
   int last_ev_cyc = 0;
   int ack_cyc = -100;
   logic prev_dc = 1'b0;

   typedef struct {
      int kind;
      int gap;
      int at;
      bit busy;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign dc_ack = auto_ack ? ack_auto : ack_dir;

   fence_flush_sequencer #(.WT_DCACHE(1'b0), .IC_SETTLE_CYCLES(N)) dut (
      .clk_i(clk), .rst_ni(rst_n), .fence_i(fence), .fence_i_i(fencei),
      .sfence_vma_i(sfence), .store_buffer_empty_i(sb_empty),
      .flush_dcache_o(dc_o), .flush_dcache_ack_i(dc_ack),
      .flush_icache_o(ic_o), .flush_tlb_o(tlb_o), .busy_o(busy), .done_o(done)
   );

   fence_flush_sequencer #(.WT_DCACHE(1'b1), .IC_SETTLE_CYCLES(N)) u_wt (
      .clk_i(clk), .rst_ni(rst_n), .fence_i(w_fence), .fence_i_i(1'b0),
      .sfence_vma_i(1'b0), .store_buffer_empty_i(sb_empty),
      .flush_dcache_o(w_dc), .flush_dcache_ack_i(1'b0),
      .flush_icache_o(w_ic), .flush_tlb_o(w_tlb), .busy_o(w_busy), .done_o(w_done)
   );

   function automatic string kname(input int k);
      case (k)
         K_DC:    return "dcache";
         K_IC:    return "icache";
         K_TLB:   return "tlb";
         default: return "done";
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One pass: DC if fence/fence.i, IC if fence.i, TLB if sfence, then done.
   // Gaps come from the settle length and single-cycle TLB/DONE steps.
   function automatic void push_pass(input logic [2:0] m, input bit follow, input int first_at);
      exp_t evs[$];
      exp_t e;
      if (m[0] | m[1]) begin e = '{K_DC, -1, -1, 1'b1}; evs.push_back(e); end
      if (m[1]) begin e = '{K_IC, -1, -1, 1'b1}; evs.push_back(e); end
      if (m[2]) begin e = '{K_TLB, (m[1] ? N + 1 : -1), -1, 1'b1}; evs.push_back(e); end
      e = '{K_DONE, (m[2] ? 1 : (m[1] ? N + 1 : -1)), -1, follow};
      evs.push_back(e);
      evs[0].at = first_at;
      foreach (evs[i]) sbq.push_back(evs[i]);
   endfunction

   task automatic observe(input int kind);
      exp_t e;
      if (sbq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got %s expected none (cycle %0d)", kname(kind), cyc);
      end else begin
         e = sbq.pop_front();
         check({"event_kind_", kname(e.kind)}, kind, e.kind);
         if (e.gap >= 0) check({"event_gap_", kname(e.kind)}, cyc - last_ev_cyc, e.gap);
         if (e.at >= 0) check({"event_cycle_", kname(e.kind)}, cyc, e.at);
         check({"busy_at_", kname(e.kind)}, int'(busy), int'(e.busy));
      end
      last_ev_cyc = cyc;
   endtask

   // Monitor: samples on the falling edge, independent of stimulus
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_dc = 1'b0;
         end else begin
            if (dc_o && !prev_dc) observe(K_DC);
            if (ic_o) observe(K_IC);
            if (tlb_o) observe(K_TLB);
            if (done) observe(K_DONE);
            if (prev_dc && !dc_o) check("dcache_release_after_ack", cyc - ack_cyc, 2);
            if (dc_ack) ack_cyc = cyc;
            prev_dc = dc_o;
         end
      end
   end

   // Memory-side D$ responder: acks 0..3 cycles after flush_dcache_o is seen
   initial begin
      int wait_cnt;
      bit acked;
      ack_auto = 1'b0;
      acked    = 1'b0;
      wait_cnt = $urandom_range(0, 3);
      forever begin
         tick();
         ack_auto = 1'b0;
         if (!dc_o) begin
            acked = 1'b0;
         end else if (auto_ack && !acked) begin
            if (wait_cnt == 0) begin
               ack_auto = 1'b1;
               acked    = 1'b1;
               wait_cnt = $urandom_range(0, 3);
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (sbq.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      check({name, "_all_events_seen"}, sbq.size(), 0);
      sbq.delete();
      tick();
   endtask

   // ack_off < 0 selects the random responder; xm is injected at cycle xoff
   task automatic run_txn(input logic [2:0] m1, input int drain, input int ack_off,
                          input logic [2:0] xm, input int xoff, input bit rnd_extra);
      logic [2:0] sched[LOOP + 1];
      logic [2:0] m2;
      int c0;
      m2 = 3'b000;
      for (int k = 0; k <= LOOP; k++) begin
         sched[k] = 3'b000;
         if (rnd_extra && k >= 1 && k <= drain && $urandom_range(0, 2) == 0)
            sched[k] = 3'($urandom_range(1, 7));
         if (k == xoff) sched[k] = sched[k] | xm;
         if (k >= 1) m2 = m2 | sched[k];
      end
      sched[0] = m1;
      c0 = cyc;
      auto_ack = (ack_off < 0);
      push_pass(m1, m2 != 3'b000, c0 + drain + 3);
      if (m2 != 3'b000) push_pass(m2, 1'b0, -1);
      $display("txn %0d: mask=%b drain=%0d follow_up=%b ack_at=%0d", txn_no, m1, drain, m2, ack_off);
      for (int k = 0; k <= LOOP; k++) begin
         {sfence, fencei, fence} = sched[k];
         sb_empty = !(k >= 1 && k <= drain);
         ack_dir  = (k == ack_off);
         tick();
      end
      {sfence, fencei, fence} = 3'b000;
      sb_empty = 1'b1;
      ack_dir  = 1'b0;
      wait_drain($sformatf("txn%0d", txn_no));
      txn_no++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst_n    = 1'b0;
      {sfence, fencei, fence} = 3'b000;
      sb_empty = 1'b1;
      ack_dir  = 1'b0;
      auto_ack = 1'b1;
      w_fence  = 1'b0;
      repeat (3) tick();
      check("reset_outputs", int'({dc_o, ic_o, tlb_o, busy, done}), 0);
      rst_n = 1'b1;
      tick();
      check("post_reset_busy", int'(busy), 0);

      // Directed cases
      run_txn(3'b001, 0, 5, 3'b000, 0, 1'b0);    // fence, dcache held 4 cycles
      run_txn(3'b010, 10, -1, 3'b000, 0, 1'b0);  // fence.i behind a full store buffer
      run_txn(3'b100, 0, 2, 3'b000, 0, 1'b0);    // sfence alone, stray ack ignored
      run_txn(3'b101, 0, -1, 3'b000, 0, 1'b0);   // fence + sfence in one pass
      run_txn(3'b001, 0, 4, 3'b100, 3, 1'b0);    // sfence during DC_FLUSH
      run_txn(3'b011, 0, 2, 3'b000, 0, 1'b0);    // ack on first DC_FLUSH cycle
      run_txn(3'b001, 0, 2, 3'b100, 3, 1'b0);    // request lands in the DONE cycle

      for (int t = 0; t < 40; t++) begin
         run_txn(3'($urandom_range(1, 7)), $urandom_range(0, 4), -1, 3'b000, 0, 1'b1);
      end

      // Reset while waiting on a D$ ack
      auto_ack = 1'b0;
      c0 = cyc;
      push_pass(3'b001, 1'b0, c0 + 3);
      {sfence, fencei, fence} = 3'b001;
      tick();
      {sfence, fencei, fence} = 3'b000;
      repeat (2) tick();
      check("pre_reset_dcache", int'(dc_o), 1);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", int'({dc_o, ic_o, tlb_o, busy, done}), 0);
      sbq.delete();
      repeat (2) tick();
      rst_n   = 1'b1;
      ack_dir = 1'b1;
      tick();
      ack_dir = 1'b0;
      repeat (8) tick();
      check("late_ack_ignored_busy", int'(busy), 0);
      check("late_ack_ignored_dcache", int'(dc_o), 0);

      // Write-through variant: no D$ step, done two cycles after DRAIN sees empty
      w_fence = 1'b1;
      tick();
      w_fence = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("wt_done_c%0d", k), int'(w_done), int'(k == 3));
         check($sformatf("wt_busy_c%0d", k), int'(w_busy), int'(k == 1 || k == 2));
         check($sformatf("wt_flush_c%0d", k), int'({w_dc, w_ic, w_tlb}), 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
